exec_hazard_ctrl: RTL and testbench

Pipeline sequencing controller for the execute stage. It drives the execute-stage `hold`, stalls and flushes fetch/decode, and inserts execute bubbles. It owns the data-memory request handshake for the registered `memOp`, resolves load-use hazards between decode and execute, and times the redirect flush after a taken `pcSel`. It also keeps a saturating stall-cycle counter for performance bring-up.

---
 rtl/exec_hazard_ctrl_pkg.sv | 14 +
 rtl/exec_hazard_ctrl_load_use.sv | 21 ++
 rtl/exec_hazard_ctrl.sv | 125 ++++++++++++
 tb/tb_exec_hazard_ctrl.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/exec_hazard_ctrl_pkg.sv
// Shared encodings for the execute-stage hazard controller.
package exec_hazard_ctrl_pkg;
  localparam logic [1:0] MEM_NONE  = 2'b00;
  localparam logic [1:0] MEM_LOAD  = 2'b01;
  localparam logic [1:0] MEM_STORE = 2'b10;

  localparam int REG_W = 5;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MEM_WAIT,
    ST_FLUSH
  } state_e;
endpackage

// File: rtl/exec_hazard_ctrl_load_use.sv
// Combinational load-use hazard compare between the execute and decode instructions.
module load_use_detect
  import exec_hazard_ctrl_pkg::*;
(
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_is_load,
  input  logic [REG_W-1:0] dec_rs1,
  input  logic [REG_W-1:0] dec_rs2,
  input  logic             dec_uses_rs1,
  input  logic             dec_uses_rs2,
  output logic             hazard
);
  logic rs1_hit, rs2_hit;

  always_comb begin
    rs1_hit = dec_uses_rs1 && (dec_rs1 == ex_rd);
    rs2_hit = dec_uses_rs2 && (dec_rs2 == ex_rd);
    // x0 is never written, so a load to it cannot create a dependency
    hazard  = ex_is_load && (ex_rd != '0) && (rs1_hit || rs2_hit);
  end
endmodule

// File: rtl/exec_hazard_ctrl.sv
// Execute-stage sequencing: memory handshake stalls, redirect flush timing,
// load-use bubbles and a saturating stall-cycle counter.
module exec_hazard_ctrl
  import exec_hazard_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int MEM_TIMEOUT  = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       memOp,
  input  logic             memAck,
  input  logic             pcSel,
  input  logic [REG_W-1:0] exRd,
  input  logic             exIsLoad,
  input  logic [REG_W-1:0] decRs1,
  input  logic [REG_W-1:0] decRs2,
  input  logic             decUsesRs1,
  input  logic             decUsesRs2,
  output logic             memReq,
  output logic             holdEX,
  output logic             holdFD,
  output logic             bubble,
  output logic             flushFD,
  output logic             memErr,
  output logic [31:0]      stallCycles
);
  localparam int              TO_W       = $clog2(MEM_TIMEOUT + 1);
  localparam logic [2:0]      FLUSH_INIT = 3'(FLUSH_CYCLES - 1);
  localparam logic [TO_W-1:0] TO_LIMIT   = TO_W'(MEM_TIMEOUT);

  state_e            state_q, state_d;
  logic [2:0]        flush_cnt_q, flush_cnt_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  logic              mem_err_q, mem_err_d;
  logic [31:0]       stall_q, stall_d;
  logic              mem_pend, hazard;

  load_use_detect u_lud (
    .ex_rd        (exRd),
    .ex_is_load   (exIsLoad),
    .dec_rs1      (decRs1),
    .dec_rs2      (decRs2),
    .dec_uses_rs1 (decUsesRs1),
    .dec_uses_rs2 (decUsesRs2),
    .hazard       (hazard)
  );

  assign mem_pend = (memOp == MEM_LOAD) || (memOp == MEM_STORE);

  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    to_cnt_d    = to_cnt_q;
    mem_err_d   = mem_err_q;
    memReq      = 1'b0;
    holdEX      = 1'b0;
    holdFD      = 1'b0;
    bubble      = 1'b0;
    flushFD     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (mem_pend) begin
          memReq = 1'b1;
          if (!memAck) begin
            holdEX   = 1'b1;
            holdFD   = 1'b1;
            to_cnt_d = '0;
            state_d  = ST_MEM_WAIT;
          end
        end else if (pcSel) begin
          flushFD = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            flush_cnt_d = FLUSH_INIT;
            state_d     = ST_FLUSH;
          end
        end else if (hazard) begin
          holdFD = 1'b1;
          bubble = 1'b1;
        end
      end
      ST_MEM_WAIT: begin
        if (memAck) begin
          memReq  = 1'b1;
          state_d = ST_IDLE;
        end else if (to_cnt_q == TO_LIMIT) begin
          // abandon: request dropped and holds released in this cycle
          mem_err_d = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          memReq   = 1'b1;
          holdEX   = 1'b1;
          holdFD   = 1'b1;
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      ST_FLUSH: begin
        flushFD     = 1'b1;
        flush_cnt_d = flush_cnt_q - 3'd1;
        if (flush_cnt_q <= 3'd1) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    stall_d = (holdFD && (stall_q != 32'hFFFF_FFFF)) ? stall_q + 32'd1 : stall_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      flush_cnt_q <= '0;
      to_cnt_q    <= '0;
      mem_err_q   <= 1'b0;
      stall_q     <= '0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      to_cnt_q    <= to_cnt_d;
      mem_err_q   <= mem_err_d;
      stall_q     <= stall_d;
    end
  end

  assign memErr      = mem_err_q;
  assign stallCycles = stall_q;
endmodule

// File: tb/tb_exec_hazard_ctrl.sv
// Directed scenarios plus randomized traffic against a cycle-level reference model.
module tb_exec_hazard_ctrl;
  localparam int FC = 2;
  localparam int TO = 4;

  logic        clk, rst;
  logic [1:0]  memOp;
  logic        memAck, pcSel, exIsLoad, decUsesRs1, decUsesRs2;
  logic [4:0]  exRd, decRs1, decRs2;
  logic        memReq, holdEX, holdFD, bubble, flushFD, memErr;
  logic [31:0] stallCycles;

  int n_checks = 0;
  int n_fail   = 0;

  exec_hazard_ctrl #(.FLUSH_CYCLES(FC), .MEM_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .memOp(memOp), .memAck(memAck), .pcSel(pcSel),
    .exRd(exRd), .exIsLoad(exIsLoad), .decRs1(decRs1), .decRs2(decRs2),
    .decUsesRs1(decUsesRs1), .decUsesRs2(decUsesRs2),
    .memReq(memReq), .holdEX(holdEX), .holdFD(holdFD), .bubble(bubble),
    .flushFD(flushFD), .memErr(memErr), .stallCycles(stallCycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    memOp = 2'b00; memAck = 1'b0; pcSel = 1'b0; exIsLoad = 1'b0;
    exRd = '0; decRs1 = '0; decRs2 = '0; decUsesRs1 = 1'b0; decUsesRs2 = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [4:0] outs;
    do_reset();
    #1;
    outs = {memReq, holdEX, holdFD, bubble, flushFD};
    n_checks++;
    if (outs !== 5'b0) begin n_fail++; $display("FAIL reset_outs: got %b expected 00000", outs); end
    n_checks++;
    if (memErr !== 1'b0) begin n_fail++; $display("FAIL reset_memErr: got %b expected 0", memErr); end
    n_checks++;
    if (stallCycles !== 32'd0) begin n_fail++; $display("FAIL reset_stall: got %0d expected 0", stallCycles); end
  endtask

  task automatic test_load_latency();
    do_reset();
    memOp = 2'b01;
    for (int c = 0; c < 4; c++) begin
      memAck = (c == 3);
      #1;
      n_checks++;
      if ({memReq, holdEX, holdFD} !== {1'b1, c < 3, c < 3}) begin
        n_fail++;
        $display("FAIL load_lat_c%0d: got req/hex/hfd %b%b%b expected 1%b%b", c, memReq, holdEX, holdFD, c < 3, c < 3);
      end
      tick();
    end
    idle_inputs();
    #1;
    n_checks++;
    if (stallCycles !== 32'd3) begin n_fail++; $display("FAIL load_lat_stall: got %0d expected 3", stallCycles); end
    n_checks++;
    if ({memReq, holdEX, holdFD} !== 3'b000) begin n_fail++; $display("FAIL load_lat_idle: got %b%b%b expected 000", memReq, holdEX, holdFD); end
  endtask

  task automatic test_store_zero_wait();
    do_reset();
    memOp = 2'b10; memAck = 1'b1;
    #1;
    n_checks++;
    if ({memReq, holdEX, holdFD} !== 3'b100) begin n_fail++; $display("FAIL store_zw: got %b%b%b expected 100", memReq, holdEX, holdFD); end
    tick();
    idle_inputs();
    #1;
    n_checks++;
    if (stallCycles !== 32'd0 || memReq !== 1'b0) begin
      n_fail++; $display("FAIL store_zw_after: got stall %0d req %b expected 0 0", stallCycles, memReq);
    end
  endtask

  task automatic test_redirect();
    int flushes = 0;
    int bubbles = 0;
    do_reset();
    pcSel = 1'b1; exIsLoad = 1'b1; exRd = 5'd5; decUsesRs1 = 1'b1; decRs1 = 5'd5;
    for (int c = 0; c < 4; c++) begin
      if (c == 1) pcSel = 1'b0;
      if (c == 2) idle_inputs();
      #1;
      if (flushFD === 1'b1) flushes++;
      if (bubble !== 1'b0) bubbles++;
      if (c == 0) begin
        n_checks++;
        if (flushFD !== 1'b1) begin n_fail++; $display("FAIL redirect_same_cycle: got %b expected 1", flushFD); end
      end
      tick();
    end
    n_checks++;
    if (flushes != FC) begin n_fail++; $display("FAIL redirect_len: got %0d expected %0d", flushes, FC); end
    n_checks++;
    if (bubbles != 0) begin n_fail++; $display("FAIL redirect_bubble: got %0d expected 0", bubbles); end
  endtask

  task automatic test_load_use();
    do_reset();
    exIsLoad = 1'b1; exRd = 5'd5; decUsesRs2 = 1'b1; decRs2 = 5'd5; decUsesRs1 = 1'b1; decRs1 = 5'd7;
    #1;
    n_checks++;
    if ({bubble, holdFD, holdEX} !== 3'b110) begin n_fail++; $display("FAIL load_use_hit: got %b%b%b expected 110", bubble, holdFD, holdEX); end
    tick();
    exIsLoad = 1'b0;
    #1;
    n_checks++;
    if ({bubble, holdFD} !== 2'b00) begin n_fail++; $display("FAIL load_use_clear: got %b%b expected 00", bubble, holdFD); end
    tick();
    n_checks++;
    if (stallCycles !== 32'd1) begin n_fail++; $display("FAIL load_use_stall: got %0d expected 1", stallCycles); end
    exIsLoad = 1'b1; exRd = 5'd0; decRs2 = 5'd0;
    #1;
    n_checks++;
    if ({bubble, holdFD} !== 2'b00) begin n_fail++; $display("FAIL load_use_x0: got %b%b expected 00", bubble, holdFD); end
    exRd = 5'd9; decRs2 = 5'd9; decUsesRs2 = 1'b0;
    #1;
    n_checks++;
    if ({bubble, holdFD} !== 2'b00) begin n_fail++; $display("FAIL load_use_unused: got %b%b expected 00", bubble, holdFD); end
    tick();
  endtask

  task automatic test_timeout();
    do_reset();
    memOp = 2'b01;
    for (int c = 0; c <= TO + 1; c++) begin
      #1;
      n_checks++;
      if ({memReq, holdEX, holdFD} !== {3{c <= TO}}) begin
        n_fail++; $display("FAIL timeout_c%0d: got %b%b%b expected %b", c, memReq, holdEX, holdFD, {3{c <= TO}});
      end
      tick();
      if (c == TO + 1) idle_inputs();
      n_checks++;
      if (memErr !== (c == TO + 1)) begin n_fail++; $display("FAIL timeout_err_c%0d: got %b expected %b", c, memErr, c == TO + 1); end
    end
    tick(); tick();
    n_checks++;
    if (memErr !== 1'b1) begin n_fail++; $display("FAIL timeout_sticky: got %b expected 1", memErr); end
    n_checks++;
    if (stallCycles !== 32'(TO + 1)) begin n_fail++; $display("FAIL timeout_stall: got %0d expected %0d", stallCycles, TO + 1); end
    do_reset();
    #1;
    n_checks++;
    if (memErr !== 1'b0) begin n_fail++; $display("FAIL timeout_rst_clear: got %b expected 0", memErr); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    memOp = 2'b01;
    tick(); tick();
    idle_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    n_checks++;
    if ({memReq, holdEX, holdFD, bubble, flushFD, memErr} !== 6'b0 || stallCycles !== 32'd0) begin
      n_fail++; $display("FAIL rst_mem_wait: got %b%b%b%b%b%b stall %0d expected all 0",
                         memReq, holdEX, holdFD, bubble, flushFD, memErr, stallCycles);
    end
    pcSel = 1'b1;
    tick();
    pcSel = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    n_checks++;
    if ({memReq, holdEX, holdFD, bubble, flushFD} !== 5'b0) begin
      n_fail++; $display("FAIL rst_flush: got %b%b%b%b%b expected 00000", memReq, holdEX, holdFD, bubble, flushFD);
    end
  endtask

  // Model tracks "how many flush cycles remain" and "how long the access has waited".
  task automatic test_random();
    bit          waiting = 0;
    int          waited = 0;
    int          flush_left = 0;
    bit          err = 0;
    logic [31:0] stalls = 0;
    logic [4:0]  exp, got;
    bit          dep;
    do_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      memOp      = 2'($urandom_range(0, 3));
      memAck     = ($urandom_range(0, 2) == 0);
      pcSel      = ($urandom_range(0, 5) == 0);
      exIsLoad   = 1'($urandom);
      exRd       = 5'($urandom_range(0, 3));
      decRs1     = 5'($urandom_range(0, 3));
      decRs2     = 5'($urandom_range(0, 3));
      decUsesRs1 = 1'($urandom);
      decUsesRs2 = 1'($urandom);
      exp = 5'b0;  // {req, hex, hfd, bubble, flush}
      if (flush_left > 0) begin
        exp = 5'b00001;
        flush_left--;
      end else if (waiting) begin
        if (memAck) begin exp = 5'b10000; waiting = 0; end
        else if (waited == TO) begin err = 1; waiting = 0; end
        else begin exp = 5'b11100; waited++; end
      end else if (memOp == 2'b01 || memOp == 2'b10) begin
        exp = memAck ? 5'b10000 : 5'b11100;
        if (!memAck) begin waiting = 1; waited = 0; end
      end else if (pcSel) begin
        exp = 5'b00001;
        flush_left = FC - 1;
      end else begin
        dep = exIsLoad && exRd != 0 &&
              ((decUsesRs1 && decRs1 == exRd) || (decUsesRs2 && decRs2 == exRd));
        if (dep) exp = 5'b00110;
      end
      if (exp[2]) stalls++;
      #1;
      got = {memReq, holdEX, holdFD, bubble, flushFD};
      n_checks++;
      if (got !== exp) begin n_fail++; $display("FAIL rand_outs_c%0d: got %b expected %b", cyc, got, exp); end
      tick();
      n_checks++;
      if (memErr !== err || stallCycles !== stalls) begin
        n_fail++; $display("FAIL rand_regs_c%0d: got err %b stall %0d expected err %b stall %0d",
                           cyc, memErr, stallCycles, err, stalls);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_load_latency();
    test_store_zero_wait();
    test_redirect();
    test_load_use();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end
endmodule
